// File: rtl/sdram_port_if.sv
// rtl/sdram_port_if.sv - single client port of the SDRAM controller
// Purpose: bundles one SDRAM controller client port.
// Signals: addr[20:0] word address, data[31:0] write data, wr/rd request strobes
//          held until ready, byte_en[3:0] write byte enables, q[31:0] read data,
//          ready one-cycle completion from the controller.
// Modports: client (bridge side), server (controller side).
interface sdram_port_if;
  logic [20:0] addr;
  logic [31:0] data;
  logic        wr;
  logic        rd;
  logic [3:0]  byte_en;
  logic [31:0] q;
  logic        ready;

  modport client (output addr, data, wr, rd, byte_en, input q, ready);
  modport server (input addr, data, wr, rd, byte_en, output q, ready);
endinterface

// File: rtl/picosoc_sdram_cached.sv
// rtl/picosoc_sdram_cached.sv - PicoSoC iomem to SDRAM bridge with direct-mapped line read cache
// Purpose: instruction fetches are served from a direct-mapped cache of
//          2^INDEX_BITS lines of 2^OFFSET_BITS words; misses fill a whole line
//          sequentially. Data reads and all writes pass through to SDRAM;
//          writes also update a matching cached word.
// Build macro: PICOSOC_SDRAM_DCACHE_EN - when defined, data reads are cached too.
// Ports:
//   clk_logic        sole clock
//   system_reset_n   asynchronous active-low reset
//   iomem_valid/instr/wstrb/addr/wdata   PicoSoC request (held until ready)
//   iomem_rdata/iomem_ready              PicoSoC response (ready is a pulse)
//   cache_flush      one-cycle pulse invalidating every line
//   mem_if           client side of the SDRAM controller port
module picosoc_sdram_cached #(
  parameter int ADDR_WIDTH  = 21,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk_logic,
  input  logic        system_reset_n,
  input  logic        iomem_valid,
  input  logic        iomem_instr,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        iomem_ready,
  input  logic        cache_flush,
  sdram_port_if.client mem_if
);

  localparam int LINE_WORDS = 1 << OFFSET_BITS;
  localparam int LINES      = 1 << INDEX_BITS;
  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int WI         = INDEX_BITS + OFFSET_BITS;
  localparam int KB         = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [KB-1:0]         k_q, k_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           rdata_q, rdata_d;

  // Storage arrays are deliberately left out of reset.
  logic [31:0]           data_q [LINES*LINE_WORDS];
  logic [TAG_BITS-1:0]   tag_q  [LINES];

  logic                  data_we;
  logic [WI-1:0]         data_widx;
  logic [31:0]           data_wval;
  logic                  tag_we;

  logic [ADDR_WIDTH-1:0] wa;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit;
  logic                  is_write;
  logic                  cacheable;
  logic [31:0]           hit_word;

  logic [ADDR_WIDTH-1:0] fill_addr;
  logic                  fill_last;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;

  logic [INDEX_BITS-1:0] pass_idx;
  logic [TAG_BITS-1:0]   pass_tag;
  logic                  pass_hit;
  logic                  pass_is_write;
  logic [31:0]           pass_word;
  logic [31:0]           merged;

  logic                  unused_inputs;
  assign unused_inputs = ^{iomem_addr, iomem_instr};

  // Request decode on the live bus address.
  assign wa       = iomem_addr[ADDR_WIDTH+1:2];
  assign req_idx  = wa[OFFSET_BITS +: INDEX_BITS];
  assign req_tag  = wa[ADDR_WIDTH-1 -: TAG_BITS];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign is_write = |iomem_wstrb;
  assign hit_word = data_q[wa[WI-1:0]];

`ifdef PICOSOC_SDRAM_DCACHE_EN
  assign cacheable = 1'b1;
`else
  assign cacheable = iomem_instr;
`endif

  // Fill sequencing: base has a zero offset, so base + k walks the line.
  assign fill_addr = base_q + ADDR_WIDTH'(k_q);
  assign fill_last = (k_q == KB'(LINE_WORDS - 1));
  assign fill_idx  = base_q[OFFSET_BITS +: INDEX_BITS];
  assign fill_tag  = base_q[ADDR_WIDTH-1 -: TAG_BITS];

  // Pass-through decode on the latched request.
  assign pass_idx      = req_addr_q[OFFSET_BITS +: INDEX_BITS];
  assign pass_tag      = req_addr_q[ADDR_WIDTH-1 -: TAG_BITS];
  assign pass_hit      = valid_q[pass_idx] && (tag_q[pass_idx] == pass_tag);
  assign pass_is_write = |wstrb_q;
  assign pass_word     = data_q[req_addr_q[WI-1:0]];

  always_comb begin
    merged = pass_word;
    for (int b = 0; b < 4; b++) begin
      if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    base_d       = base_q;
    req_addr_d   = req_addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    iomem_ready  = 1'b0;
    iomem_rdata  = rdata_q;
    data_we      = 1'b0;
    data_widx    = fill_addr[WI-1:0];
    data_wval    = mem_if.q;
    tag_we       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iomem_valid) begin
          if (!is_write && cacheable) begin
            if (hit) begin
              iomem_ready = 1'b1;
              iomem_rdata = hit_word;
              rdata_d     = hit_word;
            end else begin
              base_d           = wa & ~ADDR_WIDTH'(LINE_WORDS - 1);
              valid_d[req_idx] = 1'b0;
              k_d              = '0;
              flush_pend_d     = 1'b0;
              state_d          = ST_FILL;
            end
          end else begin
            req_addr_d = wa;
            wdata_d    = iomem_wdata;
            wstrb_d    = iomem_wstrb;
            state_d    = ST_PASS;
          end
        end
      end
      ST_FILL: begin
        if (mem_if.ready) begin
          data_we = 1'b1;
          if (fill_last) begin
            k_d    = '0;
            tag_we = 1'b1;
            // A flush seen mid-fill leaves the line invalid so the held request refills.
            if (!flush_pend_q) valid_d[fill_idx] = 1'b1;
            state_d = ST_IDLE;
          end else begin
            k_d = k_q + KB'(1);
          end
        end
      end
      ST_PASS: begin
        if (mem_if.ready) begin
          iomem_ready = 1'b1;
          state_d     = ST_IDLE;
          if (pass_is_write) begin
            if (pass_hit) begin
              data_we   = 1'b1;
              data_widx = req_addr_q[WI-1:0];
              data_wval = merged;
            end
          end else begin
            iomem_rdata = mem_if.q;
            rdata_d     = mem_if.q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cache_flush) begin
      valid_d = '0;
      if (state_q == ST_FILL) flush_pend_d = 1'b1;
    end
  end

  assign mem_if.rd      = (state_q == ST_FILL) || ((state_q == ST_PASS) && !pass_is_write);
  assign mem_if.wr      = (state_q == ST_PASS) && pass_is_write;
  assign mem_if.addr    = 21'((state_q == ST_FILL) ? fill_addr : req_addr_q);
  assign mem_if.data    = wdata_q;
  assign mem_if.byte_en = pass_is_write ? wstrb_q : 4'hF;

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      base_q       <= '0;
      req_addr_q   <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      base_q       <= base_d;
      req_addr_q   <= req_addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
    end
  end

  always_ff @(posedge clk_logic) begin
    if (data_we) data_q[data_widx] <= data_wval;
    if (tag_we) tag_q[fill_idx] <= fill_tag;
  end

endmodule

// File: tb/tb_picosoc_sdram_cached.sv
// tb/tb_picosoc_sdram_cached.sv - scoreboard bench for picosoc_sdram_cached
module tb_picosoc_sdram_cached;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        instr = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  sdram_port_if mem_if();

  picosoc_sdram_cached dut (
    .clk_logic(clk), .system_reset_n(rst_n), .iomem_valid(valid), .iomem_instr(instr),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata),
    .iomem_ready(ready), .cache_flush(flush), .mem_if(mem_if)
  );

  always #5 clk = ~clk;

  // SDRAM model: contents = init pattern XOR a written delta; ready on the lat-th request cycle.
  bit [31:0] delta [0:4095];
  int lat = 3;
  int cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int rd_log[$];

  function automatic logic [31:0] init_word(input int a);
    return (a * 32'h0100_0193) ^ 32'h5EED_1234;
  endfunction

  function automatic logic [31:0] mem_rd(input int a);
    return init_word(a) ^ delta[a & 4095];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mem_if.ready <= 1'b0;
      mem_if.q     <= 32'h0;
      cnt          <= 0;
    end else if ((mem_if.rd || mem_if.wr) && !mem_if.ready) begin
      if (cnt >= lat - 2) begin
        mem_if.ready <= 1'b1;
        cnt          <= 0;
        if (mem_if.rd) begin
          mem_if.q <= mem_rd(int'(mem_if.addr));
          rd_cnt   <= rd_cnt + 1;
          rd_log.push_back(int'(mem_if.addr));
        end else begin
          delta[int'(mem_if.addr) & 4095] <= merge(mem_rd(int'(mem_if.addr)), mem_if.data, mem_if.byte_en)
                                             ^ init_word(int'(mem_if.addr));
          wr_cnt <= wr_cnt + 1;
        end
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      mem_if.ready <= 1'b0;
      cnt          <= 0;
    end
  end

  task automatic do_access(input logic [31:0] a, input logic is_instr, input logic [3:0] strb,
                           input logic [31:0] wd, input logic fl,
                           output logic [31:0] got, output int cyc, output logic ok);
    @(posedge clk); #1;
    valid = 1'b1; addr = a; instr = is_instr; wstrb = strb; wdata = wd; flush = fl;
    cyc = 0; ok = 1'b0; got = 32'h0;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ready) begin
        ok  = 1'b1;
        got = rdata;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0; wstrb = 4'h0; flush = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    checks++; if (mem_if.rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b want=0", mem_if.rd); end
    checks++; if (mem_if.wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b want=0", mem_if.wr); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill;
    logic [31:0] got, e; int cyc; logic ok; int r0;
    rd_log.delete(); r0 = rd_cnt;
    exp_q.push_back(mem_rd(32'h40));
    do_access(32'h100, 1'b1, 4'h0, 32'h0, 1'b0, got, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || cyc != 14) begin failures++; $display("FAIL fill_latency got=%0d want=14", cyc); end
    checks++; if (got !== e) begin failures++; $display("FAIL fill_data got=%h want=%h", got, e); end
    checks++; if (rd_cnt - r0 != 4) begin failures++; $display("FAIL fill_rd_count got=%0d want=4", rd_cnt - r0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_log.size() <= i || rd_log[i] != 32'h40 + i) begin
        failures++; $display("FAIL fill_rd_addr%0d got=%h want=%h", i, (rd_log.size() > i) ? rd_log[i] : -1, 32'h40 + i);
      end
    end
    r0 = rd_cnt;
    exp_q.push_back(mem_rd(32'h41));
    do_access(32'h104, 1'b1, 4'h0, 32'h0, 1'b0, got, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || cyc != 1) begin failures++; $display("FAIL hit_latency got=%0d want=1", cyc); end
    checks++; if (got !== e) begin failures++; $display("FAIL hit_data got=%h want=%h", got, e); end
    checks++; if (rd_cnt != r0) begin failures++; $display("FAIL hit_rd_count got=%0d want=0", rd_cnt - r0); end
  endtask

  task automatic test_write_through;
    logic [31:0] got, e, old; int cyc; logic ok; int r0, w0;
    old = init_word(32'h42);
    w0 = wr_cnt;
    do_access(32'h108, 1'b0, 4'b0001, 32'h0000_00AA, 1'b0, got, cyc, ok);
    checks++; if (!ok || cyc != 4) begin failures++; $display("FAIL write_latency got=%0d want=4", cyc); end
    checks++; if (wr_cnt - w0 != 1) begin failures++; $display("FAIL write_count got=%0d want=1", wr_cnt - w0); end
    checks++; if (mem_rd(32'h42) !== {old[31:8], 8'hAA}) begin
      failures++; $display("FAIL write_sdram got=%h want=%h", mem_rd(32'h42), {old[31:8], 8'hAA});
    end
    r0 = rd_cnt;
    exp_q.push_back({old[31:8], 8'hAA});
    do_access(32'h108, 1'b1, 4'h0, 32'h0, 1'b0, got, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || cyc != 1) begin failures++; $display("FAIL wt_hit_latency got=%0d want=1", cyc); end
    checks++; if (got !== e) begin failures++; $display("FAIL wt_hit_data got=%h want=%h", got, e); end
    checks++; if (rd_cnt != r0) begin failures++; $display("FAIL wt_rd_count got=%0d want=0", rd_cnt - r0); end
  endtask

  task automatic test_conflict;
    logic [31:0] got, e, a; int cyc; logic ok; int r0;
    for (int r = 0; r < 4; r++) begin
      a = (r % 2 == 0) ? 32'h500 : 32'h100;
      r0 = rd_cnt;
      exp_q.push_back(mem_rd(int'(a >> 2)));
      do_access(a, 1'b1, 4'h0, 32'h0, 1'b0, got, cyc, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || cyc != 14) begin failures++; $display("FAIL conflict%0d_latency got=%0d want=14", r, cyc); end
      checks++; if (got !== e) begin failures++; $display("FAIL conflict%0d_data got=%h want=%h", r, got, e); end
      checks++; if (rd_cnt - r0 != 4) begin failures++; $display("FAIL conflict%0d_rd got=%0d want=4", r, rd_cnt - r0); end
    end
  endtask

  task automatic test_flush_hit;
    logic [31:0] got, e; int cyc; logic ok;
    exp_q.push_back(mem_rd(32'h40));
    do_access(32'h100, 1'b1, 4'h0, 32'h0, 1'b1, got, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || cyc != 1) begin failures++; $display("FAIL flush_hit_latency got=%0d want=1", cyc); end
    checks++; if (got !== e) begin failures++; $display("FAIL flush_hit_data got=%h want=%h", got, e); end
    exp_q.push_back(mem_rd(32'h40));
    do_access(32'h100, 1'b1, 4'h0, 32'h0, 1'b0, got, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || cyc != 14) begin failures++; $display("FAIL after_flush_latency got=%0d want=14", cyc); end
    checks++; if (got !== e) begin failures++; $display("FAIL after_flush_data got=%h want=%h", got, e); end
  endtask

  task automatic test_flush_mid_fill;
    logic [31:0] got, e; int cyc; logic ok; int r0;
    r0 = rd_cnt;
    exp_q.push_back(mem_rd(32'hC0));
    fork
      do_access(32'h300, 1'b1, 4'h0, 32'h0, 1'b0, got, cyc, ok);
      begin
        for (int i = 0; i < 100 && rd_cnt < r0 + 2; i++) @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    e = exp_q.pop_front();
    checks++; if (!ok || cyc != 27) begin failures++; $display("FAIL flush_fill_latency got=%0d want=27", cyc); end
    checks++; if (got !== e) begin failures++; $display("FAIL flush_fill_data got=%h want=%h", got, e); end
    checks++; if (rd_cnt - r0 != 8) begin failures++; $display("FAIL flush_fill_rd got=%0d want=8", rd_cnt - r0); end
  endtask

  task automatic test_data_read;
    logic [31:0] got, e; int cyc; logic ok; int r0;
    int exp_cyc[2];
    int exp_rd[2];
`ifdef PICOSOC_SDRAM_DCACHE_EN
    exp_cyc[0] = 14; exp_rd[0] = 4; exp_cyc[1] = 1; exp_rd[1] = 0;
`else
    exp_cyc[0] = 4; exp_rd[0] = 1; exp_cyc[1] = 4; exp_rd[1] = 1;
`endif
    for (int n = 0; n < 2; n++) begin
      r0 = rd_cnt;
      exp_q.push_back(mem_rd(32'h80));
      do_access(32'h200, 1'b0, 4'h0, 32'h0, 1'b0, got, cyc, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || cyc != exp_cyc[n]) begin failures++; $display("FAIL dread%0d_latency got=%0d want=%0d", n, cyc, exp_cyc[n]); end
      checks++; if (got !== e) begin failures++; $display("FAIL dread%0d_data got=%h want=%h", n, got, e); end
      checks++; if (rd_cnt - r0 != exp_rd[n]) begin failures++; $display("FAIL dread%0d_rd got=%0d want=%0d", n, rd_cnt - r0, exp_rd[n]); end
    end
  endtask

  task automatic test_reset_mid_fill;
    logic [31:0] got, e; int cyc; logic ok; int r0;
    r0 = rd_cnt;
    @(posedge clk); #1;
    valid = 1'b1; addr = 32'h600; instr = 1'b1; wstrb = 4'h0;
    for (int i = 0; i < 100 && rd_cnt < r0 + 1; i++) @(negedge clk);
    checks++; if (rd_cnt < r0 + 1) begin failures++; $display("FAIL rst_fill_start got=%0d want>=1", rd_cnt - r0); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (mem_if.rd !== 1'b0) begin failures++; $display("FAIL rst_fill_rd got=%b want=0", mem_if.rd); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_fill_ready got=%b want=0", ready); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_fill_rdata got=%h want=0", rdata); end
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    r0 = rd_cnt;
    exp_q.push_back(mem_rd(32'hC0));
    do_access(32'h300, 1'b1, 4'h0, 32'h0, 1'b0, got, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || cyc != 14) begin failures++; $display("FAIL post_rst_latency got=%0d want=14", cyc); end
    checks++; if (got !== e) begin failures++; $display("FAIL post_rst_data got=%h want=%h", got, e); end
    checks++; if (rd_cnt - r0 != 4) begin failures++; $display("FAIL post_rst_rd got=%0d want=4", rd_cnt - r0); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_through();
    test_conflict();
    test_flush_hit();
    test_flush_mid_fill();
    test_data_read();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/picosoc_sdram_cached.md
# picosoc_sdram_cached

Parametrised PicoSoC-to-SDRAM bridge with a direct-mapped, multi-word-line read cache in front of one `sdram_port_if` client port. Instruction fetches that miss trigger a sequential whole-line fill. Writes pass through to SDRAM and update any cached copy, so self-modifying code and loaders stay coherent. It sits between the PicoSoC `iomem` bus and an SDRAM controller port, and is the successor to the single-word instruction-cache bridge.

## Interface
Parameters:
- `ADDR_WIDTH`, 21: word-address width; byte address bits `[ADDR_WIDTH+1:2]` are used.
- `INDEX_BITS`, 6: line index width; lines = 2^INDEX_BITS.
- `OFFSET_BITS`, 2: word-in-line width; LINE_WORDS = 2^OFFSET_BITS; must be ≥ 0. 0 means one-word lines.

Ports:
- `clk_logic`, input, 1: sole clock.
- `system_reset_n`, input, 1: asynchronous, active-low reset.
- `iomem_valid`, input, 1: request valid; held until `iomem_ready`.
- `iomem_instr`, input, 1: request is an instruction fetch.
- `iomem_wstrb`, input, 4: byte strobes; 0 means read.
- `iomem_addr`, input, 32: byte address.
- `iomem_wdata`, input, 32: write data.
- `iomem_rdata`, output, 32: read data, valid when `iomem_ready`.
- `iomem_ready`, output, 1: one-cycle completion pulse.
- `cache_flush`, input, 1: one-cycle pulse that invalidates all lines.
- `mem_if`, client modport of `sdram_port_if`: `addr[20:0]`, `data[31:0]`, `wr`, `rd`, `byte_en[3:0]`, `q[31:0]`, `ready`.

## Operation
- **Address split** (word address): tag = upper `ADDR_WIDTH-INDEX_BITS-OFFSET_BITS` bits, then index, then offset.
- **Storage**: data array of LINE_WORDS×2^INDEX_BITS words; tag array and valid bit per line.
- **Hit**: line valid and tag equal. Evaluated combinationally on `iomem_addr`.
- **States**: IDLE, FILL, PASS.
- **IDLE**:
  - Instruction read that hits: `iomem_rdata` = cached word and `iomem_ready` = 1 in the same cycle. No SDRAM access.
  - Instruction read that misses: latch line base address and tag; clear that line's valid bit; go to FILL with word counter k = 0.
  - Data read, or any write: latch request; go to PASS.
- **FILL**:
  - Drive `mem_if.rd` = 1 with `mem_if.addr` = line base + k.
  - On each `mem_if.ready`, store `mem_if.q` to word k and increment k.
  - On the ready for k = LINE_WORDS-1: write the tag, set valid, return to IDLE.
  - The still-held request then hits the next cycle.
- **PASS**:
  - Drive `mem_if.rd`, or `mem_if.wr` with `byte_en` = strobes, `data` = wdata, and the latched word address.
  - On `mem_if.ready`: `iomem_ready` = 1, `iomem_rdata` = `mem_if.q` for reads; return to IDLE.
  - Write that completes to a line that is valid with a matching tag: merge the strobed bytes into the cached word in the same cycle (write-through update).
- **`mem_if` handshake**: `rd`/`wr` are held constant until `ready`; at most one of them is high; both are 0 in IDLE.
- **`cache_flush`**:
  - Clears all valid bits on the next edge, in any state.
  - If it arrives during FILL, the fill completes but the line is not marked valid; the request re-misses and refills.
  - If flush and a hit occur in the same cycle, the hit is still served this cycle.
- **Reset**: all valid bits 0, state IDLE, k = 0, `iomem_ready` = 0, `iomem_rdata` = 0, `mem_if.rd`/`wr` = 0. Reset during FILL or PASS abandons the transaction. Data and tag arrays are not cleared.

## Timing
- Instruction hit: 0 wait cycles; ready in the same cycle as valid.
- Instruction miss: 1 cycle (IDLE→FILL) + Σ LINE_WORDS SDRAM latencies + 1 cycle hit.
- Next fill word: `rd` for k+1 is asserted in the cycle after the ready for k.
- PASS latency: 1 cycle + SDRAM latency.
- `iomem_ready` is never asserted in two consecutive cycles for the same request.
- `iomem_rdata` holds its last value when not ready (registered in PASS; combinational on hit).

## Configuration
- `PICOSOC_SDRAM_DCACHE_EN`:
  - Defined: data reads are also cached. They use the hit/FILL path exactly like instruction reads.
  - Undefined: data reads always take PASS and never allocate or read cache.
- Writes behave identically in both builds.

## Test plan
- Reset, then instruction read at 0x100, SDRAM latency 3 → 4 `rd` at word addresses 0x40–0x43; `iomem_ready` after 1+4×3+1 = 14 cycles; returns word 0x40's data. A repeat read at 0x104 returns ready in the same cycle with no `mem_if.rd`.
- Fill line 0x40, then write 0x000000AA with `wstrb` = 4'b0001 to 0x108 → one SDRAM write; instruction read at 0x108 hits and returns the old word with byte 0 = 0xAA.
- Two addresses 0x100 and 0x100 + 4×LINE_WORDS×2^INDEX_BITS alternate → each access misses and refills; no stale data returned.
- `cache_flush` pulsed during the third fill word → fill finishes, the request re-misses, and 4 more reads are issued before ready.
- Reset asserted mid-FILL → outputs 0 the same cycle; after release, the first fetch to that line misses.
- Data read at 0x200 with `PICOSOC_SDRAM_DCACHE_EN` undefined → one `rd` per access, never a hit. With the macro defined → the second access hits.
